frame_end_request_gen: RTL and testbench
========================================

Name: frame_end_request_gen

Overview:
- Upstream neighbour of the end-of-frame reset stage.
- Tracks line completions inside a frame of the line-scan capture path and issues the one-cycle end-of-frame request pulse consumed by that stage, whose input is named reset_after_end_frame_request_out.
- Enforces a hold-off after each request so the downstream 40-cycle diode-request window always completes before the next request.

Parameters:
LINES_PER_FRAME, 256, lines per complete frame; legal range 1..2^LINE_W-1
LINE_W, 9, line counter width
HOLDOFF_CYC, 64, post-request guard cycles; must be >= 42
TIMEOUT_CYC, 20000, idle cycles before forced frame end (only with macro)
TMO_W, 16, timeout counter width

Ports:
clk_200MHz_i  in  1  system clock, 200 MHz
reset_n  in  1  asynchronous, active-low reset
enable_i  in  1  block enable, level
frame_start_i  in  1  one-cycle pulse, frame begins
line_done_i  in  1  one-cycle pulse, one line completed
reset_after_end_frame_request_out  out  1  one-cycle end-of-frame request
line_count_o  out  LINE_W  lines counted in the current frame
frame_active_o  out  1  high in ACTIVE state
frame_short_o  out  1  one-cycle pulse, frame restarted before completion
frame_timeout_o  out  1  one-cycle pulse, frame ended by timeout
frame_count_o  out  16  completed frames, wraps at 2^16

Behaviour:
- All outputs registered. reset_n low clears, asynchronously, all outputs to 0, state to IDLE, pending flag and all counters.
- IDLE: enable_i and frame_start_i -> ACTIVE, line_cnt<=0. line_done_i is ignored.
- ACTIVE: line_done_i -> line_cnt+1.
  - line_done_i while line_cnt==LINES_PER_FRAME-1 -> REQ; line_count_o shows LINES_PER_FRAME.
  - frame_start_i -> line_cnt<=0, frame_short_o pulses 1 cycle, stay ACTIVE, no request. This also applies with line_cnt==0.
  - frame_start_i and line_done_i in the same cycle -> frame_start wins; the line is dropped.
  - enable_i low -> IDLE with no request. line_count_o holds its value.
- REQ: request high for exactly this one cycle, frame_count_o+1 (wraps), holdoff counter<=HOLDOFF_CYC-1, then -> HOLDOFF.
- Latency: the final line_done_i is sampled at edge N; the request is high during cycle N+1.
- HOLDOFF:
  - line_done_i is ignored.
  - frame_start_i sets the pending flag.
  - The counter decrements to 0. At 0: pending and enable_i -> ACTIVE (line_cnt<=0, pending cleared); otherwise -> IDLE (pending cleared).
- Request spacing is never less than HOLDOFF_CYC+1 cycles.
- enable_i low during REQ or HOLDOFF does not abort the sequence; it only blocks re-entry into ACTIVE.
- frame_active_o==1 exactly in ACTIVE.

Optional Feature:
- Macro FRAME_TIMEOUT_EN.
- Defined: in ACTIVE with line_cnt>=1, an idle counter (TMO_W bits) counts cycles since the last accepted line_done_i and clears on each one. Reaching TIMEOUT_CYC -> REQ, with frame_timeout_o pulsed in the same cycle as the request. frame_count_o increments normally.
- Undefined: no idle counter; ACTIVE waits indefinitely; frame_timeout_o tied 0.

Decomposition:
- Package frame_end_pkg holds:
  - state enum: IDLE, ACTIVE, REQ, HOLDOFF, 2-bit encoding
  - FRAME_CNT_W=16
  - default parameter constants
- One sub-module, frame_holdoff_timer: loadable down-counter with zero flag, reused for the hold-off counter and, under the macro, the idle timeout counter.
- FSM stays in the top.

Test Plan:
1. LINES_PER_FRAME=4: frame_start, then 4 line_done spaced 10 cycles -> request high 1 cycle, one cycle after the 4th line_done; line_count_o=4; frame_count_o 0->1; no frame_short_o.
2. frame_start 5 cycles into HOLDOFF (HOLDOFF_CYC=64) -> ACTIVE entered 64 cycles after the request, line_count_o=0; 4 more lines -> second request; frame_count_o=2.
3. frame_start after 2 lines -> frame_short_o 1-cycle pulse, line_count_o=0, no request; 4 further lines -> request.
4. reset_n low at line 3 -> all outputs 0 immediately, without waiting for a clock edge; subsequent line_done ignored until enable and frame_start.
5. frame_start and line_done in the same cycle at line 3 -> line_count_o=0, frame_short_o pulses, no request.
6. FRAME_TIMEOUT_EN, TIMEOUT_CYC=100: 1 line_done then silence -> request plus frame_timeout_o, 100 cycles after that line. Without the macro -> no request within 10000 cycles.

Source files
------------

// File: rtl/frame_end_pkg.sv
`default_nettype none
// ============================================================================
// Module  : frame_end_pkg
// Purpose : Shared types and constants for the end-of-frame request
//           generator: FSM state encoding, frame counter width and the
//           default parameter set.
// Revision: 1.0 - initial release
// ============================================================================
package frame_end_pkg;

  // Frame-tracking states, 2-bit encoding.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACTIVE  = 2'd1,
    REQ     = 2'd2,
    HOLDOFF = 2'd3
  } state_e;

  localparam int FRAME_CNT_W = 16;

  localparam int DEF_LINES_PER_FRAME = 256;
  localparam int DEF_LINE_W          = 9;
  localparam int DEF_HOLDOFF_CYC     = 64;
  localparam int DEF_TIMEOUT_CYC     = 20000;
  localparam int DEF_TMO_W           = 16;

endpackage : frame_end_pkg
`default_nettype wire

// File: rtl/frame_end_request_gen_timer.sv
`default_nettype none
// ============================================================================
// Module  : frame_holdoff_timer
// Purpose : Loadable down-counter with zero flag. The count saturates at 0.
//           Load has priority over decrement.
// Ports   : clk_200MHz_i - clock
//           reset_n      - asynchronous active-low reset (count -> 0)
//           load_i       - load load_val_i into the counter
//           load_val_i   - value to load
//           dec_i        - decrement by one (ignored when already 0)
//           zero_o       - counter currently holds 0
// Revision: 1.0 - initial release
// ============================================================================
module frame_holdoff_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk_200MHz_i,
  input  logic             reset_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_200MHz_i or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);

endmodule : frame_holdoff_timer
`default_nettype wire

// File: rtl/frame_end_request_gen.sv
`default_nettype none
// ============================================================================
// Module  : frame_end_request_gen
// Purpose : Counts completed lines within a frame and issues a one-cycle
//           end-of-frame request (reset_after_end_frame_request_out), then
//           holds off for HOLDOFF_CYC cycles so the downstream diode-request
//           window completes before the next request.
// Macro   : FRAME_TIMEOUT_EN - when defined, an ACTIVE frame with at least
//           one line that sees no line_done_i for TIMEOUT_CYC cycles is
//           forced to end (request plus frame_timeout_o).
// Ports   : clk_200MHz_i, reset_n (async, active-low)
//           enable_i, frame_start_i, line_done_i         - control inputs
//           reset_after_end_frame_request_out            - request pulse
//           line_count_o, frame_count_o                  - counters
//           frame_active_o, frame_short_o, frame_timeout_o - status
// Revision: 1.0 - initial release
// ============================================================================
module frame_end_request_gen
  import frame_end_pkg::*;
#(
  parameter int LINES_PER_FRAME = DEF_LINES_PER_FRAME,
  parameter int LINE_W          = DEF_LINE_W,
  parameter int HOLDOFF_CYC     = DEF_HOLDOFF_CYC,
  parameter int TIMEOUT_CYC     = DEF_TIMEOUT_CYC,
  parameter int TMO_W           = DEF_TMO_W
) (
  input  logic                   clk_200MHz_i,
  input  logic                   reset_n,
  input  logic                   enable_i,
  input  logic                   frame_start_i,
  input  logic                   line_done_i,
  output logic                   reset_after_end_frame_request_out,
  output logic [LINE_W-1:0]      line_count_o,
  output logic                   frame_active_o,
  output logic                   frame_short_o,
  output logic                   frame_timeout_o,
  output logic [FRAME_CNT_W-1:0] frame_count_o
);

  localparam int                HOLD_W    = $clog2(HOLDOFF_CYC);
  localparam logic [LINE_W-1:0] LAST_LINE = LINE_W'(LINES_PER_FRAME - 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLDOFF_CYC - 1);

  // Elaboration-time guard against an unusable parameter set.
  if ((LINES_PER_FRAME < 1) || (LINES_PER_FRAME > (2**LINE_W) - 1) ||
      (HOLDOFF_CYC < 42) || (TIMEOUT_CYC < 1) ||
      (TIMEOUT_CYC >= 2**TMO_W)) begin : g_bad_cfg
    $error("frame_end_request_gen: illegal parameter set");
  end

  state_e                 state_q,     state_d;
  logic                   req_q,       req_d;
  logic [LINE_W-1:0]      line_cnt_q,  line_cnt_d;
  logic                   active_q,    active_d;
  logic                   short_q,     short_d;
  logic                   tmo_q,       tmo_d;
  logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic                   pending_q,   pending_d;

  logic hold_load;
  logic hold_zero;
  logic enter_req;

  frame_holdoff_timer #(.CNT_W(HOLD_W)) u_hold_timer (
    .clk_200MHz_i (clk_200MHz_i),
    .reset_n      (reset_n),
    .load_i       (hold_load),
    .load_val_i   (HOLD_LOAD),
    .dec_i        (state_q == HOLDOFF),
    .zero_o       (hold_zero)
  );

`ifdef FRAME_TIMEOUT_EN
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYC - 1);

  logic idle_load;
  logic idle_zero;

  // Reloaded on every accepted non-final line; otherwise free-runs down and
  // parks at 0, which only matters while ACTIVE with line_cnt >= 1.
  frame_holdoff_timer #(.CNT_W(TMO_W)) u_idle_timer (
    .clk_200MHz_i (clk_200MHz_i),
    .reset_n      (reset_n),
    .load_i       (idle_load),
    .load_val_i   (TMO_LOAD),
    .dec_i        (1'b1),
    .zero_o       (idle_zero)
  );
`endif

  always_comb begin
    state_d     = state_q;
    line_cnt_d  = line_cnt_q;
    frame_cnt_d = frame_cnt_q;
    pending_d   = pending_q;
    req_d       = 1'b0;
    short_d     = 1'b0;
    tmo_d       = 1'b0;
    hold_load   = 1'b0;
    enter_req   = 1'b0;
`ifdef FRAME_TIMEOUT_EN
    idle_load   = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (enable_i && frame_start_i) begin
          state_d    = ACTIVE;
          line_cnt_d = '0;
        end
      end

      ACTIVE: begin
        // Disable dominates; a restart dominates a coincident line.
        if (!enable_i) begin
          state_d = IDLE;
        end else if (frame_start_i) begin
          line_cnt_d = '0;
          short_d    = 1'b1;
        end else if (line_done_i) begin
          line_cnt_d = line_cnt_q + 1'b1;
          if (line_cnt_q == LAST_LINE) begin
            enter_req = 1'b1;
          end
`ifdef FRAME_TIMEOUT_EN
          else begin
            idle_load = 1'b1;
          end
        end else if ((line_cnt_q != '0) && idle_zero) begin
          enter_req = 1'b1;
          tmo_d     = 1'b1;
`endif
        end
      end

      REQ: begin
        // A frame start arriving during the request is kept for re-entry.
        state_d   = HOLDOFF;
        hold_load = 1'b1;
        pending_d = pending_q | frame_start_i;
      end

      HOLDOFF: begin
        if (hold_zero) begin
          if ((pending_q || frame_start_i) && enable_i) begin
            state_d    = ACTIVE;
            line_cnt_d = '0;
          end else begin
            state_d = IDLE;
          end
          pending_d = 1'b0;
        end else begin
          pending_d = pending_q | frame_start_i;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (enter_req) begin
      state_d     = REQ;
      req_d       = 1'b1;
      frame_cnt_d = frame_cnt_q + 1'b1;
    end

    active_d = (state_d == ACTIVE);
  end

  always_ff @(posedge clk_200MHz_i or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      req_q       <= 1'b0;
      line_cnt_q  <= '0;
      active_q    <= 1'b0;
      short_q     <= 1'b0;
      tmo_q       <= 1'b0;
      frame_cnt_q <= '0;
      pending_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      line_cnt_q  <= line_cnt_d;
      active_q    <= active_d;
      short_q     <= short_d;
      tmo_q       <= tmo_d;
      frame_cnt_q <= frame_cnt_d;
      pending_q   <= pending_d;
    end
  end

  assign reset_after_end_frame_request_out = req_q;
  assign line_count_o                      = line_cnt_q;
  assign frame_active_o                    = active_q;
  assign frame_short_o                     = short_q;
  assign frame_timeout_o                   = tmo_q;
  assign frame_count_o                     = frame_cnt_q;

endmodule : frame_end_request_gen
`default_nettype wire

// File: tb/tb_frame_end_request_gen.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : tb_frame_end_request_gen
// Purpose : Self-checking bench for frame_end_request_gen. Directed frame
//           scenarios followed by random stimulus, all compared every cycle
//           against a timestamp-based behavioural model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_frame_end_request_gen;

  localparam int L_FRAME = 4;
  localparam int LINE_W  = 9;
  localparam int HOLD    = 64;
  localparam int TMO     = 100;
  localparam int TMO_W   = 16;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              enable_i = 1'b0;
  logic              frame_start_i = 1'b0;
  logic              line_done_i = 1'b0;
  logic              req_o;
  logic [LINE_W-1:0] line_count_o;
  logic              frame_active_o;
  logic              frame_short_o;
  logic              frame_timeout_o;
  logic [15:0]       frame_count_o;

  always #2.5 clk = ~clk;

  frame_end_request_gen #(
    .LINES_PER_FRAME (L_FRAME),
    .LINE_W          (LINE_W),
    .HOLDOFF_CYC     (HOLD),
    .TIMEOUT_CYC     (TMO),
    .TMO_W           (TMO_W)
  ) dut (
    .clk_200MHz_i                      (clk),
    .reset_n                           (reset_n),
    .enable_i                          (enable_i),
    .frame_start_i                     (frame_start_i),
    .line_done_i                       (line_done_i),
    .reset_after_end_frame_request_out (req_o),
    .line_count_o                      (line_count_o),
    .frame_active_o                    (frame_active_o),
    .frame_short_o                     (frame_short_o),
    .frame_timeout_o                   (frame_timeout_o),
    .frame_count_o                     (frame_count_o)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mode: 0 = waiting for a frame, 1 = counting lines, 2 = busy after a
  // request until edge busy_end (request cycle plus guard time).
  int mode, lc, fc, last_line, busy_end, edge_no;
  bit pending;
  bit e_req, e_short, e_tmo;

  task automatic model_reset();
    mode = 0; lc = 0; fc = 0; pending = 0;
    e_req = 0; e_short = 0; e_tmo = 0;
  endtask

  task automatic issue_request(input bit by_timeout);
    e_req    = 1;
    e_tmo    = by_timeout;
    fc       = (fc + 1) % 65536;
    mode     = 2;
    busy_end = edge_no + HOLD + 1;
  endtask

  task automatic model_edge(input bit en, input bit fs, input bit ld);
    edge_no++;
    e_req = 0; e_short = 0; e_tmo = 0;
    case (mode)
      0: if (en && fs) begin mode = 1; lc = 0; end
      1: begin
        if (!en) mode = 0;
        else if (fs) begin lc = 0; e_short = 1; end
        else if (ld) begin
          lc++;
          last_line = edge_no;
          if (lc == L_FRAME) issue_request(0);
        end
`ifdef FRAME_TIMEOUT_EN
        else if (lc >= 1 && (edge_no - last_line) >= TMO) issue_request(1);
`endif
      end
      default: begin
        pending = pending | fs;
        if (edge_no == busy_end) begin
          if (pending && en) begin mode = 1; lc = 0; end
          else mode = 0;
          pending = 0;
        end
      end
    endcase
  endtask

  task automatic compare_all(input string pfx);
    check_val({pfx, "_req"},    32'(req_o),           32'(e_req));
    check_val({pfx, "_lines"},  32'(line_count_o),    32'(lc));
    check_val({pfx, "_active"}, 32'(frame_active_o),  32'(mode == 1));
    check_val({pfx, "_short"},  32'(frame_short_o),   32'(e_short));
    check_val({pfx, "_tmo"},    32'(frame_timeout_o), 32'(e_tmo));
    check_val({pfx, "_frames"}, 32'(frame_count_o),   32'(fc));
  endtask

  // One clock: drive at negedge, model at posedge, compare at next negedge.
  task automatic step(input bit en, input bit fs, input bit ld);
    enable_i = en; frame_start_i = fs; line_done_i = ld;
    @(posedge clk);
    model_edge(en, fs, ld);
    @(negedge clk);
    compare_all("cyc");
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0);
  endtask

  task automatic line_after(input int gap);
    idle(gap - 1);
    step(1, 0, 1);
  endtask

  int cnt_req, cnt_tmo, wait_cyc, ld_pct;

  initial begin
    model_reset();
    edge_no = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    compare_all("rst");
    reset_n = 1'b1;

    // 1: full frame, lines spaced 10 cycles
    step(1, 1, 0);
    for (int i = 0; i < L_FRAME; i++) line_after(10);
    check_val("t1_req", 32'(req_o), 1);
    check_val("t1_lines", 32'(line_count_o), L_FRAME);
    check_val("t1_frames", 32'(frame_count_o), 1);

    // 2: frame start during hold-off is remembered
    idle(5);
    step(1, 1, 0);
    wait_cyc = 0;
    while (!frame_active_o && wait_cyc < 200) begin
      step(1, 0, 0);
      wait_cyc++;
    end
    check_val("t2_active", 32'(frame_active_o), 1);
    check_val("t2_lines", 32'(line_count_o), 0);
    for (int i = 0; i < L_FRAME; i++) line_after(3);
    check_val("t2_frames", 32'(frame_count_o), 2);
    idle(80);

    // 3: restart after 2 lines
    step(1, 1, 0);
    line_after(3); line_after(3);
    step(1, 1, 0);
    check_val("t3_short", 32'(frame_short_o), 1);
    check_val("t3_lines", 32'(line_count_o), 0);
    for (int i = 0; i < L_FRAME; i++) line_after(4);
    check_val("t3_req", 32'(req_o), 1);
    idle(80);

    // 4: asynchronous reset at line 3
    step(1, 1, 0);
    line_after(3); line_after(3);
    enable_i = 1; frame_start_i = 0; line_done_i = 1;
    #1 reset_n = 1'b0;
    #0.5;
    model_reset();
    compare_all("t4_async");
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) step(1, 0, 1);
    check_val("t4_ignored", 32'(line_count_o), 0);

    // 5: frame start and line in the same cycle
    step(1, 1, 0);
    line_after(3); line_after(3);
    step(1, 1, 1);
    check_val("t5_short", 32'(frame_short_o), 1);
    check_val("t5_lines", 32'(line_count_o), 0);
    check_val("t5_req", 32'(req_o), 0);
    for (int i = 0; i < L_FRAME; i++) line_after(2);
    idle(80);

    // 6: one line then silence
    step(1, 1, 0);
    line_after(2);
    cnt_req = 0; cnt_tmo = 0;
    for (int i = 0; i < 10000; i++) begin
      step(1, 0, 0);
      cnt_req += int'(req_o);
      cnt_tmo += int'(frame_timeout_o);
    end
`ifdef FRAME_TIMEOUT_EN
    check_val("t6_req_cnt", 32'(cnt_req), 1);
    check_val("t6_tmo_cnt", 32'(cnt_tmo), 1);
`else
    check_val("t6_req_cnt", 32'(cnt_req), 0);
    check_val("t6_tmo_cnt", 32'(cnt_tmo), 0);
`endif

    // Random phase: alternate busy and sparse line traffic.
    for (int blk = 0; blk < 12; blk++) begin
      ld_pct = (blk % 3 == 2) ? 1 : 25;
      for (int i = 0; i < 500; i++) begin
        step($urandom_range(0, 99) < 97,
             $urandom_range(0, 99) < 3,
             $urandom_range(0, 99) < ld_pct);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_frame_end_request_gen
`default_nettype wire
